sram_ctrl: RTL

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: turns a held CPU request into a setup / strobe / hold
// access with a programmable strobe width, and answers with a one-cycle acknowledge.
module sram_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cs,
    input  logic        i_we,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_dat,
    output logic [15:0] o_dat,
    output logic        o_ack,
    output logic [15:0] o_sram_addr,
    output logic [15:0] o_sram_dq,
    input  logic [15:0] i_sram_dq,
    output logic        o_sram_dq_oe,
    output logic        o_sram_ce_n,
    output logic        o_sram_oe_n,
    output logic        o_sram_we_n
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       we_q;
    logic       latch, capture, we_nx;
    logic       ce_n_nx, oe_n_nx, we_n_nx, dq_oe_nx, ack_nx;

    // Strobes are decoded from the next state so every SRAM pin comes straight off a flop.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        latch   = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (i_cs) begin
                    latch   = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                cnt_n   = CNT_LOAD;
                state_n = STROBE;
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    capture = ~we_q;
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            HOLD: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Direction comes from the latched request; the live i_we only matters on the latch cycle.
        we_nx    = latch ? i_we : we_q;
        ce_n_nx  = (state_n == IDLE);
        oe_n_nx  = ~(((state_n == SETUP) || (state_n == STROBE)) && ~we_nx);
        we_n_nx  = ~((state_n == STROBE) && we_nx);
        dq_oe_nx = (state_n != IDLE) && we_nx;
        ack_nx   = (state_n == HOLD);
    end

    // The SRAM address/data output registers double as the request latch.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            we_q         <= 1'b0;
            o_dat        <= 16'd0;
            o_ack        <= 1'b0;
            o_sram_addr  <= 16'd0;
            o_sram_dq    <= 16'd0;
            o_sram_dq_oe <= 1'b0;
            o_sram_ce_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_we_n  <= 1'b1;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            o_ack        <= ack_nx;
            o_sram_dq_oe <= dq_oe_nx;
            o_sram_ce_n  <= ce_n_nx;
            o_sram_oe_n  <= oe_n_nx;
            o_sram_we_n  <= we_n_nx;
            if (latch) begin
                we_q        <= i_we;
                o_sram_addr <= i_addr;
                if (i_we) begin
                    o_sram_dq <= i_dat;
                end
            end
            if (capture) begin
                o_dat <= i_sram_dq;
            end
        end
    end

endmodule
